// File: rtl/proc_feeder_pkg.sv
// Shared types and default sizing for the processor program feeder.
package proc_feeder_pkg;

  localparam int FEEDER_DEPTH   = 32;
  localparam int FEEDER_TIMEOUT = 64;

  // PAUSE is only reachable when single-step support is compiled in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    EXEC  = 3'd2,
    HALT  = 3'd3,
    ERROR = 3'd4,
    PAUSE = 3'd5
  } feeder_state_t;

endpackage

// File: rtl/proc_prog_feeder_prog_mem.sv
// Program memory: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset so a program survives Resetn.
module prog_mem
  import proc_feeder_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = FEEDER_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; gating against a running program is done by the caller.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/proc_prog_feeder.sv
// Program feeder for the processor's DIN/Run/Done/pc_inc interface.
// Handshake: Run is high for exactly one cycle (ISSUE) per instruction; the
// processor pulses pc_inc for each word it consumes from DIN and raises Done
// for one cycle when the instruction retires. Done is only looked at in EXEC.
// Optional single-step support: define PROG_FEEDER_SINGLE_STEP_EN.
module proc_prog_feeder
  import proc_feeder_pkg::*;
#(
  parameter int WIDTH   = 9,
  parameter int DEPTH   = FEEDER_DEPTH,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = FEEDER_TIMEOUT,
  parameter int CW      = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [AW-1:0]    end_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pc_inc,
  input  logic             Done,
`ifdef PROG_FEEDER_SINGLE_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  output logic [WIDTH-1:0] DIN,
  output logic             Run,
  output logic [AW-1:0]    pc,
  output logic             busy,
  output logic             halted,
  output logic             timeout_err,
  output logic [CW-1:0]    instr_count,
  output feeder_state_t    state_dbg
);

  localparam int WDW = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  feeder_state_t   state, state_nxt;
  logic [AW-1:0]   pc_q, pc_nxt, end_q;
  logic [WDW-1:0]  wd_q;
  logic [CW-1:0]   cnt_q;
  logic            wrapped_q;
  logic            idle_like, start_ok, pc_step, wrap_now, prog_end;

  // Start and memory writes are accepted only while no program is running.
  assign idle_like = (state == IDLE) || (state == HALT) || (state == ERROR);
  assign start_ok  = Start && idle_like;
  assign pc_step   = pc_inc && ((state == ISSUE) || (state == EXEC));
  assign wrap_now  = pc_step && (&pc_q);
  assign pc_nxt    = pc_step ? pc_q + 1'b1 : pc_q;
  // End check uses the post-increment pc; any wrap since Start also ends it.
  assign prog_end  = wrapped_q || wrap_now || (pc_nxt > end_q);

  prog_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (Clock),
    .we    (wr_en && idle_like),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (pc_q),
    .rdata (DIN)
  );

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HALT, ERROR: if (Start) state_nxt = ISSUE;
      ISSUE:             state_nxt = EXEC;
      EXEC: begin
        if (Done) begin
          if (prog_end) state_nxt = HALT;
`ifdef PROG_FEEDER_SINGLE_STEP_EN
          else if (step_mode) state_nxt = PAUSE;
`endif
          else state_nxt = ISSUE;
        end else if (wd_q == WD_LAST) begin
          state_nxt = ERROR;
        end
      end
`ifdef PROG_FEEDER_SINGLE_STEP_EN
      PAUSE:             if (step) state_nxt = ISSUE;
`endif
      default:           state_nxt = IDLE;
    endcase
  end

  // Program counter, end register, wrap flag and retired-instruction counter.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pc_q      <= '0;
      end_q     <= '0;
      cnt_q     <= '0;
      wrapped_q <= 1'b0;
    end else if (start_ok) begin
      pc_q      <= '0;
      end_q     <= end_addr;
      cnt_q     <= '0;
      wrapped_q <= 1'b0;
    end else begin
      pc_q <= pc_nxt;
      if (wrap_now) wrapped_q <= 1'b1;
      if ((state == EXEC) && Done && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Watchdog: cleared at each issue, counts EXEC cycles, frozen elsewhere.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                wd_q <= '0;
    else if (state == ISSUE)    wd_q <= '0;
    else if (state == EXEC)     wd_q <= wd_q + 1'b1;
  end

  assign Run         = (state == ISSUE);
`ifdef PROG_FEEDER_SINGLE_STEP_EN
  assign busy        = (state == ISSUE) || (state == EXEC) || (state == PAUSE);
`else
  assign busy        = (state == ISSUE) || (state == EXEC);
`endif
  assign halted      = (state == HALT);
  assign timeout_err = (state == ERROR);
  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_proc_prog_feeder.sv
// Bench for proc_prog_feeder: program-table vectors driven through a small
// processor model, DIN checked against an expected-word queue, plus
// hand-written sequences for timeout, write protection, async reset and
// (when PROG_FEEDER_SINGLE_STEP_EN is defined) single stepping.
module tb_proc_prog_feeder;
  import proc_feeder_pkg::*;

  localparam int WIDTH = 9;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int CW    = 16;

  logic             Clock, Resetn, Start, wr_en, pc_inc, Done;
  logic [AW-1:0]    end_addr, wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] DIN;
  logic             Run, busy, halted, timeout_err;
  logic [AW-1:0]    pc;
  logic [CW-1:0]    instr_count;
  feeder_state_t    state_dbg;
`ifdef PROG_FEEDER_SINGLE_STEP_EN
  logic             step_mode, step;
`endif

  proc_prog_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(64), .CW(CW)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .Start       (Start),
    .end_addr    (end_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pc_inc      (pc_inc),
    .Done        (Done),
`ifdef PROG_FEEDER_SINGLE_STEP_EN
    .step_mode   (step_mode),
    .step        (step),
`endif
    .DIN         (DIN),
    .Run         (Run),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .timeout_err (timeout_err),
    .instr_count (instr_count),
    .state_dbg   (state_dbg)
  );

  // Clock and global time limit.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  // Scoreboard state.
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] shadow [DEPTH];
  logic [AW-1:0]    paddr;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] end_a;
    logic [31:0]   imm;
    bit            late;
    int            runs;
    logic [AW-1:0] pc_exp;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    tick();
  endtask

  task automatic write_mem(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic sb_pop_check(input string name);
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s actual=%0h expected=queue_empty", name, DIN);
    end else begin
      check(name, 32'(DIN), 32'(exp_q.pop_front()));
    end
  endtask

  // One instruction of the processor model, entered in the ISSUE cycle.
  // Normal: pc_inc on fetch (and again for an immediate), Done 3 cycles
  // after Run. Late: the only pc_inc arrives together with Done.
  task automatic proc_step(input bit imm, input bit late);
    sb_pop_check("din_fetch");
    check("pc_at_issue", 32'(pc), 32'(paddr));
    if (!late) begin pc_inc = 1'b1; paddr = paddr + 1'b1; end
    tick();
    pc_inc = 1'b0;
    check("run_one_cycle", 32'(Run), 32'd0);
    if (imm && !late) begin
      sb_pop_check("din_imm");
      pc_inc = 1'b1; paddr = paddr + 1'b1;
    end
    tick();
    pc_inc = 1'b0;
    tick();
    Done = 1'b1;
    if (late) begin pc_inc = 1'b1; paddr = paddr + 1'b1; end
    tick();
    Done = 1'b0; pc_inc = 1'b0;
  endtask

  task automatic wait_run(input string name);
    bit seen;
    seen = 1'b0;
    for (int g = 0; g < 50; g++) begin
      if (Run) begin seen = 1'b1; break; end
      tick();
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int a, runs;
    v = vecs[idx];
    a = 0;
    while (a <= int'(v.end_a)) begin
      exp_q.push_back(shadow[a]);
      if (v.imm[a] && !v.late) begin
        exp_q.push_back(shadow[a + 1]);
        a += 2;
      end else a += 1;
    end
    Start = 1'b1; end_addr = v.end_a;
    tick();
    Start = 1'b0; end_addr = ~v.end_a;
    paddr = '0; runs = 0;
    for (int g = 0; g < 100; g++) begin
      if (halted || timeout_err) break;
      if (Run) begin
        runs++;
        proc_step(v.imm[paddr] && !v.late, v.late);
      end else tick();
    end
    check("vec_halted", 32'(halted), 32'd1);
    check("vec_runs", 32'(runs), 32'(v.runs));
    check("vec_pc", 32'(pc), 32'(v.pc_exp));
    check("vec_instr_count", 32'(instr_count), 32'(v.runs));
    check("vec_no_timeout", 32'(timeout_err), 32'd0);
    check("vec_not_busy", 32'(busy), 32'd0);
    check("vec_sb_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Read a word back through DIN by walking pc with pc_inc, then reset.
  task automatic read_word(input logic [AW-1:0] a, input string name);
    exp_q.push_back(shadow[a]);
    Start = 1'b1; end_addr = 5'd31;
    tick();
    Start = 1'b0;
    pc_inc = 1'b1;
    for (int i = 0; i < int'(a); i++) tick();
    pc_inc = 1'b0;
    sb_pop_check(name);
    do_reset();
  endtask

  initial begin
    int errs;
    Resetn = 1'b0; Start = 1'b0; end_addr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; pc_inc = 1'b0; Done = 1'b0;
`ifdef PROG_FEEDER_SINGLE_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    vecs[0] = '{end_a: 5'd2,  imm: 32'h1,  late: 1'b0, runs: 2,  pc_exp: 5'd3};
    vecs[1] = '{end_a: 5'd0,  imm: 32'h0,  late: 1'b0, runs: 1,  pc_exp: 5'd1};
    vecs[2] = '{end_a: 5'd4,  imm: 32'h0,  late: 1'b0, runs: 5,  pc_exp: 5'd5};
    vecs[3] = '{end_a: 5'd3,  imm: 32'h2,  late: 1'b0, runs: 3,  pc_exp: 5'd4};
    vecs[4] = '{end_a: 5'd5,  imm: 32'h5,  late: 1'b0, runs: 4,  pc_exp: 5'd6};
    vecs[5] = '{end_a: 5'd2,  imm: 32'h0,  late: 1'b1, runs: 3,  pc_exp: 5'd3};
    vecs[6] = '{end_a: 5'd31, imm: 32'h0,  late: 1'b1, runs: 32, pc_exp: 5'd0};

    // Reset values.
    tick(); tick();
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_run", 32'(Run), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    Resetn = 1'b1;
    tick();

    // Load program memory; first three words are the reference program.
    for (int i = 0; i < DEPTH; i++) shadow[i] = WIDTH'($urandom_range(0, 510));
    shadow[0] = 9'o100; shadow[1] = 9'o005; shadow[2] = 9'o010;
    for (int i = 0; i < DEPTH; i++) write_mem(AW'(i), shadow[i]);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Async reset in EXEC with instr_count=5; Start while busy ignored.
    for (int i = 0; i < 5; i++) exp_q.push_back(shadow[i]);
    Start = 1'b1; end_addr = 5'd31;
    tick();
    Start = 1'b0;
    paddr = '0;
    for (int i = 0; i < 5; i++) begin
      wait_run("ar_wait_run");
      proc_step(1'b0, 1'b0);
    end
    tick();
    Start = 1'b1; end_addr = 5'd0;
    tick();
    Start = 1'b0;
    check("busy_start_count", 32'(instr_count), 32'd5);
    check("busy_start_pc", 32'(pc), 32'd5);
    check("busy_start_state", 32'(state_dbg), 32'(EXEC));
    #2 Resetn = 1'b0;
    #1;
    check("ar_state", 32'(state_dbg), 32'(IDLE));
    check("ar_count", 32'(instr_count), 32'd0);
    check("ar_pc", 32'(pc), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_run", 32'(Run), 32'd0);
    check("ar_halted", 32'(halted), 32'd0);
    check("ar_timeout", 32'(timeout_err), 32'd0);
    tick();
    Resetn = 1'b1;
    tick();
    exp_q.delete();

    // Watchdog: no Done after Run.
    Start = 1'b1; end_addr = 5'd3;
    tick();
    Start = 1'b0;
    check("wd_run_issue", 32'(Run), 32'd1);
    tick();
    errs = 0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (Run || !busy || timeout_err) errs++;
    end
    check("wd_exec_hold", 32'(errs), 32'd0);
    tick();
    check("wd_fired", 32'(timeout_err), 32'd1);
    check("wd_state", 32'(state_dbg), 32'(ERROR));
    check("wd_not_busy", 32'(busy), 32'd0);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (Run || !timeout_err) errs++;
    end
    check("wd_sticky", 32'(errs), 32'd0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("wd_cleared", 32'(timeout_err), 32'd0);
    check("wd_restart_run", 32'(Run), 32'd1);
    do_reset();

    // Write during EXEC is dropped.
    Start = 1'b1; end_addr = 5'd0;
    tick();
    Start = 1'b0;
    tick();
    write_mem(5'd1, 9'h1FF);
    Done = 1'b1; pc_inc = 1'b1;
    tick();
    Done = 1'b0; pc_inc = 1'b0;
    check("wp_halted", 32'(halted), 32'd1);
    read_word(5'd1, "wp_exec_write_ignored");

    // Write in HALT lands.
    Start = 1'b1; end_addr = 5'd0;
    tick();
    Start = 1'b0;
    tick();
    Done = 1'b1; pc_inc = 1'b1;
    tick();
    Done = 1'b0; pc_inc = 1'b0;
    check("wp_halted2", 32'(halted), 32'd1);
    write_mem(5'd1, 9'h1FF);
    shadow[1] = 9'h1FF;
    read_word(5'd1, "wp_halt_write_lands");

`ifdef PROG_FEEDER_SINGLE_STEP_EN
    // Single step: park in PAUSE until step.
    step_mode = 1'b1;
    exp_q.push_back(shadow[0]);
    Start = 1'b1; end_addr = 5'd3;
    tick();
    Start = 1'b0;
    paddr = '0;
    proc_step(1'b0, 1'b0);
    check("ss_pause", 32'(state_dbg), 32'(PAUSE));
    check("ss_busy", 32'(busy), 32'd1);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (Run || state_dbg != PAUSE) errs++;
      tick();
    end
    check("ss_no_run", 32'(errs), 32'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("ss_step_run", 32'(Run), 32'd1);
    step_mode = 1'b0;
    exp_q.delete();
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/proc_prog_feeder.md
Name: proc_prog_feeder

Overview:
- Instruction/operand source on the far side of the processor's DIN/Run/Done/pc_inc interface.
- Holds a small loadable program memory and a program counter, and drives the current word onto DIN.
- Advances the program counter on each pc_inc pulse from the processor.
- Issues Run per instruction, waits for Done, and sequences the program until an end address, with a watchdog on Done.

Parameters:
- WIDTH, 9, instruction/data word width; must match the processor's DIN width.
- DEPTH, 32, program memory words; power of two.
- AW, $clog2(DEPTH), address and program-counter width.
- TIMEOUT, 64, maximum cycles allowed in EXEC without Done before the watchdog fires.
- CW, 16, width of the executed-instruction counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle pulse; begins execution from address 0.
- end_addr  in  AW  last program address; sampled on Start.
- wr_en  in  1  program-memory write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- pc_inc  in  1  from the processor; advance the program counter.
- Done  in  1  from the processor; current instruction finished.
- DIN  out  WIDTH  word at mem[pc], to the processor.
- Run  out  1  to the processor; instruction issue pulse.
- pc  out  AW  current program counter.
- busy  out  1  high in ISSUE or EXEC.
- halted  out  1  program completed normally.
- timeout_err  out  1  watchdog fired; sticky until next Start.
- instr_count  out  CW  instructions completed since Start.

Behaviour:
- Reset (async, Resetn=0): state IDLE; pc=0; Run=0; busy=0; halted=0; timeout_err=0; instr_count=0; end register=0; watchdog=0. Memory contents are not reset.
- DIN = mem[pc], combinational read. Changes in the same cycle pc changes; the processor samples it on the next edge.
- Memory writes take effect only in IDLE, HALT or ERROR. A write in ISSUE or EXEC is ignored.
- State IDLE: on Start, pc←0, end register←end_addr, instr_count←0, halted←0, timeout_err←0, go to ISSUE.
- State ISSUE: Run=1 for exactly this one cycle; watchdog←0; go to EXEC.
- State EXEC: Run=0; watchdog increments every cycle.
  - Done=1: instr_count saturating-increments (holds at all ones). If pc (after any pc_inc this cycle) > end register, or the increment wrapped pc to 0, go to HALT. Otherwise go to ISSUE.
  - Done=0 with watchdog == TIMEOUT-1: go to ERROR.
- pc_inc: honoured only in ISSUE and EXEC; pc←pc+1, wrapping DEPTH-1→0, and a wrap ends the program as above. Ignored in IDLE, HALT and ERROR.
- Simultaneous pc_inc and Done in one cycle: increment first, then perform the end comparison on the new pc.
- HALT: halted=1; busy=0; Start behaves as in IDLE.
- ERROR: timeout_err=1; Run=0; Start behaves as in IDLE.
- Start while busy is ignored.
- Reset mid-operation: immediate return to the reset values above. The processor is reset on the same Resetn.
- busy = (state==ISSUE || state==EXEC).

Optional Feature:
- Macro: PROG_FEEDER_SINGLE_STEP_EN.
- Defined: adds inputs step_mode (1 bit) and step (1-bit pulse), plus state PAUSE.
  - On Done with step_mode=1 and the program not ended, go to PAUSE instead of ISSUE.
  - PAUSE→ISSUE on step.
  - Watchdog is frozen in PAUSE; busy=1 in PAUSE.
- Undefined: ports and state are absent; behaviour exactly as above.

Decomposition:
- Package proc_feeder_pkg: state enum typedef feeder_state_t (IDLE, ISSUE, EXEC, HALT, ERROR, PAUSE) and default constants FEEDER_DEPTH and FEEDER_TIMEOUT.
- One sub-module, prog_mem: single write port, async read, DEPTH×WIDTH.
- FSM, pc, watchdog and counter live in proc_prog_feeder.

Test Plan:
- Load mem[0..2]=9'o100, 9'o005, 9'o010, end_addr=2, Start; model Done 3 cycles after Run, with pc_inc once per fetch plus once for the immediate → 2 Run pulses, DIN sequence 100,005,010, halted=1, instr_count=2, pc=3.
- Done never asserted after Run → ERROR exactly TIMEOUT (64) cycles after EXEC entry, timeout_err=1, Run stays 0; Start clears it.
- end_addr=31, DEPTH=32, pc_inc at pc=31 together with Done → pc wraps to 0, HALT, halted=1.
- wr_en during EXEC to addr 1 with 9'h1FF → mem[1] unchanged on readback after HALT; the same write in HALT succeeds.
- Resetn pulled low while in EXEC with instr_count=5 → all outputs at reset values asynchronously, before the next Clock edge.
- With PROG_FEEDER_SINGLE_STEP_EN and step_mode=1: after first Done the block stays in PAUSE for 10 cycles with no Run; a step pulse gives Run on the next cycle.
